// File: rtl/spi_prog_regfile_pkg.sv
// spi_prog_regfile shared types: FSM states, command codes, word framing.
// Defining SPI_PARITY_EN appends an even-parity bit to every data word.
package spi_prog_pkg;

   typedef enum logic [2:0] {
      WAIT_CS_HIGH,
      IDLE,
      CMD,
      ADDR,
      DATA
   } state_t;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

`ifdef SPI_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   // bits per data word on the wire, parity included
   function automatic int word_bits(input int data_w);
      return data_w + PAR_BITS;
   endfunction

endpackage

// File: rtl/spi_prog_regfile_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser for an asynchronous SPI pin,
// followed by a registered edge detect (one-CLK rise/fall pulses).
module spi_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // synchronise the pin and keep one cycle of history
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_prog_regfile.sv
// spi_prog_regfile: oversampled SPI mode-0 register file with shadow/commit.
// Define SPI_PARITY_EN for an even-parity bit after every data word.
module spi_prog_regfile
   import spi_prog_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_sclk,
   input  logic                       i_cs,
   input  logic                       i_sdi,
   output logic                       o_sdo,
   output logic                       o_sdo_oe,
   output logic [NUM_REGS*DATA_W-1:0] o_prog_data,
   output logic                       o_commit,
   output logic                       o_frame_err
);

   localparam int WORD_BITS = word_bits(DATA_W);
   localparam int CNT_W     = $clog2(WORD_BITS + ADDR_W + 1);
   localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_BITS - 1);
   localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(NUM_REGS - 1);
`ifdef SPI_PARITY_EN
   localparam logic [CNT_W-1:0]  PAR_POS   = CNT_W'(DATA_W);
`endif

   logic w_unused_sclk;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_lvl;
   logic w_cs_rise;
   logic w_cs_fall;
   logic w_sdi;
   logic w_unused_sdi_rise;
   logic w_unused_sdi_fall;

   spi_sync_edge u_sclk (
      .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sclk),
      .o_level(w_unused_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_sync_edge u_cs (
      .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cs),
      .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_sync_edge u_sdi (
      .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sdi),
      .o_level(w_sdi), .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall)
   );

   state_t r_state;
   state_t w_next;

   logic [CNT_W-1:0]     r_cnt;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_cmd;
   logic                 r_bad;
   logic                 r_have_word;
   logic [WORD_BITS-1:0] r_shift;
   logic [DATA_W-1:0]    r_shadow [NUM_REGS];
   logic [DATA_W-1:0]    r_prog   [NUM_REGS];
   logic                 r_commit;
   logic                 r_err;
   logic                 r_sdo;

   logic [ADDR_W-1:0]    w_addr_nxt;
   logic [ADDR_W-1:0]    w_addr_inc;
   logic                 w_addr_ok;
   logic [WORD_BITS-1:0] w_word_full;
   logic [DATA_W-1:0]    w_word;
   logic                 w_par_ok;
   logic                 w_word_done;
   logic [DATA_W-1:0]    w_rd_word;
   logic                 w_rd_bit;
   logic                 w_commit_now;
   logic                 w_err_set;
   logic                 w_err_clr;
   logic                 w_sdo_oe;

   assign w_addr_nxt  = (r_addr << 1) | ADDR_W'(w_sdi);
   assign w_addr_inc  = (r_addr == ADDR_MAX) ? '0 : r_addr + ADDR_W'(1);
   assign w_addr_ok   = int'(w_addr_nxt) < NUM_REGS;
   assign w_word_full = (r_shift << 1) | WORD_BITS'(w_sdi);
   assign w_word_done = (r_cnt == WORD_LAST);
   assign w_rd_word   = (int'(r_addr) < NUM_REGS) ? r_prog[r_addr] : '0;

`ifdef SPI_PARITY_EN
   assign w_word   = w_word_full[DATA_W:1];
   assign w_par_ok = ~^w_word_full;
`else
   assign w_word   = w_word_full[DATA_W-1:0];
   assign w_par_ok = 1'b1;
`endif

   // readback bit for the current position, MSB first, parity last
   always_comb begin
      w_rd_bit = 1'b0;
      for (int i = 0; i < DATA_W; i++)
         if (int'(r_cnt) == DATA_W - 1 - i) w_rd_bit = w_rd_word[i];
`ifdef SPI_PARITY_EN
      if (r_cnt == PAR_POS) w_rd_bit = ^w_rd_word;
`endif
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= WAIT_CS_HIGH;
      else       r_state <= w_next;
   end

   // FSM next state; a CS rise always wins over an SCLK edge
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         WAIT_CS_HIGH: if (w_cs_lvl) w_next = IDLE;
         IDLE:         if (w_cs_fall) w_next = CMD;
         CMD: begin
            if (w_cs_rise)        w_next = IDLE;
            else if (w_sclk_rise) w_next = ADDR;
         end
         ADDR: begin
            if (w_cs_rise) w_next = IDLE;
            else if (w_sclk_rise && r_cnt == ADDR_LAST) w_next = DATA;
         end
         DATA:    if (w_cs_rise) w_next = IDLE;
         default: w_next = WAIT_CS_HIGH;
      endcase
   end

   // FSM outputs: end-of-frame verdict and readback enable
   always_comb begin
      w_commit_now = 1'b0;
      w_err_set    = 1'b0;
      w_err_clr    = 1'b0;
      if (w_cs_rise) begin
         unique case (r_state)
            CMD, ADDR: w_err_set = 1'b1;
            DATA: begin
               if (r_cnt == '0 && r_have_word && !r_bad) begin
                  w_commit_now = (r_cmd == CMD_WRITE);
                  w_err_clr    = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end
            default: ;
         endcase
      end
      w_sdo_oe = (r_state == DATA) && (r_cmd == CMD_READ) && !w_cs_lvl;
   end

   // frame datapath: shift-in, shadow writes, readback, commit
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_cmd       <= CMD_READ;
         r_bad       <= 1'b0;
         r_have_word <= 1'b0;
         r_shift     <= '0;
         r_commit    <= 1'b0;
         r_err       <= 1'b0;
         r_sdo       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_shadow[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            r_prog[i]   <= RESET_VAL[i*DATA_W +: DATA_W];
         end
      end else begin
         r_commit <= w_commit_now;
         if (w_commit_now) r_prog <= r_shadow;
         if (w_err_set)      r_err <= 1'b1;
         else if (w_err_clr) r_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_cs_fall) begin
                  r_shadow    <= r_prog;
                  r_cnt       <= '0;
                  r_addr      <= '0;
                  r_bad       <= 1'b0;
                  r_have_word <= 1'b0;
                  r_sdo       <= 1'b0;
               end
            end
            CMD: if (!w_cs_rise && w_sclk_rise) r_cmd <= w_sdi;
            ADDR: begin
               if (!w_cs_rise && w_sclk_rise) begin
                  r_addr <= w_addr_nxt;
                  if (r_cnt == ADDR_LAST) begin
                     r_cnt <= '0;
                     if (!w_addr_ok) r_bad <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            DATA: begin
               if (!w_cs_rise && w_sclk_rise) begin
                  r_shift <= w_word_full;
                  if (w_word_done) begin
                     r_cnt       <= '0;
                     r_addr      <= w_addr_inc;
                     r_have_word <= 1'b1;
                     if (r_cmd == CMD_WRITE) begin
                        if (!r_bad && w_par_ok) r_shadow[r_addr] <= w_word;
                        else                    r_bad <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               if (!w_cs_rise && w_sclk_fall && r_cmd == CMD_READ)
                  r_sdo <= w_rd_bit;
            end
            default: ;
         endcase
      end
   end

   // flatten the active registers onto the configuration bus
   always_comb begin
      o_prog_data = '0;
      for (int i = 0; i < NUM_REGS; i++)
         o_prog_data[i*DATA_W +: DATA_W] = r_prog[i];
   end

   assign o_sdo       = w_sdo_oe & r_sdo;
   assign o_sdo_oe    = w_sdo_oe;
   assign o_commit    = r_commit;
   assign o_frame_err = r_err;

endmodule

// File: tb/tb_spi_prog_regfile.sv
// tb_spi_prog_regfile: directed table plus random frames for spi_prog_regfile,
// checked against an array model of the register file (SPI_PARITY_EN aware).
`timescale 1ns/1ps
module tb_spi_prog_regfile;

   localparam int NR = 8;
   localparam int DW = 8;
   localparam int AW = 3;
`ifdef SPI_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int WB = DW + (PAR ? 1 : 0);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic cs = 1'b1;
   logic sdi = 1'b0;
   logic sdo, sdo_oe, commit, ferr;
   logic [NR*DW-1:0] prog;

   int n_cmp = 0;
   int n_bad = 0;
   int total_commits = 0;
   int oe_err;
   int commits_seen;
   int commit_lat;
   bit flip_par = 1'b0;

   logic [7:0] tx [4];
   logic [7:0] rx [4];
   logic       rxp [4];
   logic [7:0] e_rd [4];
   logic [7:0] mreg [NR];

   always #5 clk = ~clk;

   spi_prog_regfile #(
      .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .RESET_VAL('0)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs(cs), .i_sdi(sdi),
      .o_sdo(sdo), .o_sdo_oe(sdo_oe), .o_prog_data(prog),
      .o_commit(commit), .o_frame_err(ferr)
   );

   always @(posedge clk) if (commit === 1'b1) total_commits++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_bus();
      logic [63:0] b;
      for (int i = 0; i < NR; i++) b[i*8 +: 8] = mreg[i];
      return b;
   endfunction

   // one SCLK period: set SDI, sample SDO just before the rise
   task automatic send_bit(input logic b, input int exp_oe, output logic s);
      sdi = b;
      tick(4);
      s = sdo;
      if (exp_oe >= 0 && sdo_oe !== exp_oe[0]) oe_err++;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
   endtask

   task automatic run_frame(input bit wr, input int addr, input int nw,
                            input int extra, input int stop);
      logic s;
      logic [2:0] a;
      int rd, c0, na;
      a = addr[2:0];
      rd = wr ? 0 : 1;
      na = (stop == 2) ? 1 : AW;
      oe_err = 0;
      c0 = total_commits;
      cs = 1'b0;
      sdi = 1'b0;
      tick(4);
      send_bit(wr, 0, s);
      if (stop != 1)
         for (int i = 0; i < na; i++) send_bit(a[AW-1-i], 0, s);
      if (stop == 0) begin
         for (int w = 0; w < nw; w++) begin
            for (int b = DW - 1; b >= 0; b--) begin
               send_bit(wr ? tx[w][b] : 1'b0, rd, s);
               rx[w][b] = s;
            end
            if (PAR) begin
               send_bit(wr ? ((^tx[w]) ^ flip_par) : 1'b0, rd, s);
               rxp[w] = s;
            end
         end
         for (int e = 0; e < extra; e++) send_bit(1'($urandom), rd, s);
      end
      sdi = 1'b0;
      tick(4);
      cs = 1'b1;
      commit_lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (commit === 1'b1 && commit_lat == 0) commit_lat = i;
      end
      tick(4);
      commits_seen = total_commits - c0;
   endtask

   // reference: a frame is accepted only if it is whole and clean
   task automatic do_frame(input bit wr, input int addr, input int nw,
                           input int extra, input int stop, input bit badpar);
      bit ok;
      int e_commit;
      ok = (stop == 0) && (nw >= 1) && (extra == 0) && !(wr && badpar && PAR);
      for (int w = 0; w < nw; w++) e_rd[w] = mreg[(addr + w) % NR];
      if (ok && wr)
         for (int w = 0; w < nw; w++) mreg[(addr + w) % NR] = tx[w];
      e_commit = (ok && wr) ? 1 : 0;
      flip_par = badpar;
      run_frame(wr, addr, nw, extra, stop);
      flip_par = 1'b0;
      check("commit_cnt", commits_seen, e_commit);
      if (e_commit == 1)
         check("commit_lat", (commit_lat >= 1 && commit_lat <= 5), 1'b1);
      check("frame_err", ferr, !ok);
      check("prog_bus", prog, model_bus());
      check("sdo_oe", oe_err, 0);
      if (!wr && stop == 0)
         for (int w = 0; w < nw; w++) begin
            check("rd_word", rx[w], e_rd[w]);
            if (PAR) check("rd_par", rxp[w], ^e_rd[w]);
         end
   endtask

   typedef struct {
      bit         wr;
      int         addr;
      int         nw;
      logic [7:0] d0;
      logic [7:0] d1;
      int         extra;
      int         stop;
      int         x_commit;
      bit         x_err;
      int         ci;
      logic [7:0] cv;
      logic [7:0] r0;
      logic [7:0] r1;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic s;
      int c0;
      tbl[0]  = '{1, 2, 1, 8'hA5, 8'h00, 0, 0, 1, 0, 2, 8'hA5, 0, 0};
      tbl[1]  = '{1, 7, 2, 8'h11, 8'h22, 0, 0, 1, 0, 0, 8'h22, 0, 0};
      tbl[2]  = '{1, 1, 0, 8'h00, 8'h00, 5, 0, 0, 1, 1, 8'h00, 0, 0};
      tbl[3]  = '{1, 3, 1, 8'h5A, 8'h00, 0, 0, 1, 0, 3, 8'h5A, 0, 0};
      tbl[4]  = '{1, 4, 1, 8'h3C, 8'h00, 0, 0, 1, 0, 4, 8'h3C, 0, 0};
      tbl[5]  = '{0, 4, 1, 8'h00, 8'h00, 0, 0, 0, 0, 4, 8'h3C, 8'h3C, 0};
      tbl[6]  = '{0, 7, 2, 8'h00, 8'h00, 0, 0, 0, 0, 7, 8'h11, 8'h11, 8'h22};
      tbl[7]  = '{1, 2, 1, 8'hFF, 8'h00, 0, 1, 0, 1, 2, 8'hA5, 0, 0};
      tbl[8]  = '{0, 2, 1, 8'h00, 8'h00, 0, 0, 0, 0, 2, 8'hA5, 8'hA5, 0};
      tbl[9]  = '{1, 5, 0, 8'h00, 8'h00, 0, 0, 0, 1, 5, 8'h00, 0, 0};
      tbl[10] = '{0, 0, 1, 8'h00, 8'h00, 3, 0, 0, 1, 0, 8'h22, 8'h22, 0};
      tbl[11] = '{1, 6, 1, 8'h77, 8'h00, 0, 2, 0, 1, 6, 8'h00, 0, 0};
      tbl[12] = '{1, 6, 1, 8'hC3, 8'h00, 0, 0, 1, 0, 6, 8'hC3, 0, 0};
      for (int i = 0; i < NR; i++) mreg[i] = 8'h00;

      tick(3);
      rst = 1'b0;
      tick(6);
      check("rst_prog", prog, 64'h0);
      check("rst_commit", commit, 1'b0);
      check("rst_err", ferr, 1'b0);
      check("rst_oe", sdo_oe, 1'b0);
      check("rst_sdo", sdo, 1'b0);

      // reset in the middle of a write frame, CS kept low afterwards
      c0 = total_commits;
      oe_err = 0;
      cs = 1'b0;
      tick(4);
      send_bit(1'b1, 0, s);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 0, s);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0, s);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      for (int i = 0; i < 9; i++) send_bit(1'b1, 0, s);
      tick(4);
      cs = 1'b1;
      tick(12);
      check("midrst_prog", prog, 64'h0);
      check("midrst_commit", total_commits - c0, 0);
      check("midrst_err", ferr, 1'b0);
      check("midrst_oe", oe_err, 0);

      for (int i = 0; i < 13; i++) begin
         tx[0] = tbl[i].d0;
         tx[1] = tbl[i].d1;
         do_frame(tbl[i].wr, tbl[i].addr, tbl[i].nw, tbl[i].extra,
                  tbl[i].stop, 1'b0);
         check("tbl_commit", commits_seen, tbl[i].x_commit);
         check("tbl_err", ferr, tbl[i].x_err);
         check("tbl_reg", prog[tbl[i].ci*8 +: 8], tbl[i].cv);
         if (!tbl[i].wr && tbl[i].stop == 0) begin
            if (tbl[i].nw > 0) check("tbl_rd0", rx[0], tbl[i].r0);
            if (tbl[i].nw > 1) check("tbl_rd1", rx[1], tbl[i].r1);
         end
      end

`ifdef SPI_PARITY_EN
      tx[0] = 8'h01;
      do_frame(1'b1, 5, 1, 0, 0, 1'b1);
      check("par_bad_err", ferr, 1'b1);
      check("par_bad_reg", prog[47:40], 8'h00);
      do_frame(1'b1, 5, 1, 0, 0, 1'b0);
      check("par_ok_err", ferr, 1'b0);
      check("par_ok_reg", prog[47:40], 8'h01);
`endif

      for (int n = 0; n < 40; n++) begin
         int extra, stop;
         for (int w = 0; w < 4; w++) tx[w] = 8'($urandom);
         extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WB - 1) : 0;
         stop  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
         do_frame(1'($urandom), $urandom_range(0, NR - 1),
                  $urandom_range(0, 3), extra, stop, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
